twiddle_addr_sequencer: RTL and testbench
=========================================

TWIDDLE_ADDR_SEQUENCER -- requirements
Module: twiddle_addr_sequencer

Interface
REQ-001 Parameter NFFT, default 128: FFT points; power of two, at least 4.
REQ-002 Parameter DATA_WIDTH, default 16: twiddle component width.
REQ-003 Parameter STAGE, default 0: SDF stage index, 0..log2(NFFT)-1.
REQ-004 clk  input  1: single clock; all state updates on rising edge.
REQ-005 rst_n  input  1: reset, asynchronous, active-low.
REQ-006 clear  input  1: synchronous frame restart.
REQ-007 in_valid  input  1: one stage-input sample accepted this cycle.
REQ-008 rom_addr  output  log2(NFFT/2): twiddle ROM address, combinational from state.
REQ-009 rom_real, rom_imag  input  DATA_WIDTH each: combinational ROM read data for rom_addr.
REQ-010 tw_real, tw_imag  output  DATA_WIDTH each: registered twiddle for the butterfly multiplier.
REQ-011 tw_valid  output  1: tw_real/tw_imag apply to the sample accepted one cycle earlier.
REQ-012 tw_bypass  output  1: registered; butterfly passes the sample unrotated (upper half of block).
REQ-013 frame_done  output  1: one-cycle pulse, registered, after the last sample (index NFFT-1) of a frame.

Function
REQ-014 Internal sample counter n, log2(NFFT) bits, increments by 1 only on cycles with in_valid=1 and wraps from NFFT-1 to 0.
REQ-015 Block length L = NFFT>>STAGE, half H = L/2, block position p = n mod L.
REQ-016 FSM states: IDLE (no sample since reset/clear), UPPER (p<H), LOWER (p>=H).
REQ-017 FSM transitions: IDLE->UPPER on first in_valid; UPPER->LOWER when p reaches H; LOWER->UPPER when p wraps to 0; any state->IDLE on clear without in_valid.
REQ-018 In LOWER: rom_addr = (p-H) << STAGE; in UPPER/IDLE: rom_addr = 0.
REQ-019 Address range: maximum (H-1)<<STAGE = NFFT/2 - 2^STAGE; no overflow.
REQ-020 Sample accepted in LOWER: tw_real/tw_imag <= rom_real/rom_imag; tw_valid=1; tw_bypass=0 on the next cycle.
REQ-021 Sample accepted in UPPER: tw_valid=1; tw_bypass=1; tw_real/tw_imag hold.
REQ-022 Latency: exactly one cycle from accepted sample to tw_valid.
REQ-023 No in_valid: tw_valid=0, tw_bypass=0; n, FSM state, and tw_real/tw_imag hold; gaps of any length are legal.
REQ-024 frame_done=1 on the cycle after the sample with n=NFFT-1 is accepted; 0 otherwise.
REQ-025 clear has priority over counting.
REQ-026 clear with in_valid=0: n=0, state IDLE, tw_valid=0, frame_done=0.
REQ-027 clear with in_valid=1: the sample is index 0 of a new frame (n<=1, state UPPER, tw_bypass=1 next cycle).
REQ-028 STAGE=log2(NFFT)-1 (L=2): rom_addr is always 0; UPPER and LOWER alternate per sample.
REQ-029 IFFT conjugation lives in ROM contents; this block passes rom data through unmodified.

Reset
REQ-030 On rst_n=0, immediately: n=0, state IDLE, tw_real=0, tw_imag=0, tw_valid=0, tw_bypass=0, frame_done=0.
REQ-031 Reset asserted mid-frame discards the partial frame; the first in_valid after release is index 0.

Structure
REQ-032 Package ifft_pkg holds NFFT, DATA_WIDTH, LOG2N = log2(NFFT), ADDR_W = LOG2N-1, and the FSM state enum.
REQ-033 The twiddle ROM is instantiated outside this block, beside it in the stage.
REQ-034 One sub-module, sample_pos_counter, holds n, wrap, and clear logic.

Verification
REQ-035 STAGE=0, 128 contiguous in_valid: tw_bypass=1 for samples 0..63; rom_addr 0,1,..,63 for samples 64..127; frame_done pulse one cycle after sample 127.
REQ-036 STAGE=2 (L=32), 128 samples: in each of 4 blocks, rom_addr 0,4,8,..,60 for p=16..31; tw_* equals the ROM word registered one cycle later.
REQ-037 STAGE=6, 8 samples: rom_addr always 0; tw_bypass pattern 1,0,1,0,...
REQ-038 STAGE=1, in_valid every 3rd cycle: tw_valid only one cycle after each accepted sample; address sequence identical to the contiguous case.
REQ-039 clear at sample 40 with in_valid=1: that sample is index 0, next frame_done after 128 more accepted samples; clear alone: tw_valid=0 next cycle.
REQ-040 rst_n pulled low mid-cycle at sample 70: all outputs 0 without a clock edge; resume at index 0 after release.

Source files
------------

// File: rtl/ifft_pkg.sv
// Shared IFFT constants and the twiddle sequencer FSM state type.
package ifft_pkg;
  localparam int NFFT       = 128;
  localparam int DATA_WIDTH = 16;
  localparam int LOG2N      = $clog2(NFFT);
  localparam int ADDR_W     = LOG2N - 1;

  typedef enum logic [1:0] {ST_IDLE, ST_UPPER, ST_LOWER} tw_state_e;
endpackage

// File: rtl/sample_pos_counter.sv
// Frame sample index: counts accepted samples, wraps at NFFT, restarts on clear.
module sample_pos_counter #(
  parameter int NFFT = 128,
  localparam int LG  = $clog2(NFFT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic [LG-1:0] n,
  output logic          last
);
  // A sample arriving together with clear is index 0, so it is never the last one.
  assign last = in_valid & ~clear & (n == LG'(NFFT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        n <= '0;
    else if (clear)    n <= in_valid ? LG'(1) : '0;
    else if (in_valid) n <= n + LG'(1);
  end
endmodule

// File: rtl/twiddle_addr_sequencer.sv
// Per-stage twiddle ROM addressing and registered twiddle/bypass output for an SDF FFT stage.
module twiddle_addr_sequencer #(
  parameter int NFFT       = ifft_pkg::NFFT,
  parameter int DATA_WIDTH = ifft_pkg::DATA_WIDTH,
  parameter int STAGE      = 0,
  localparam int LG        = $clog2(NFFT),
  localparam int AW        = LG - 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic [AW-1:0]         rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_real,
  input  logic [DATA_WIDTH-1:0] rom_imag,
  output logic [DATA_WIDTH-1:0] tw_real,
  output logic [DATA_WIDTH-1:0] tw_imag,
  output logic                  tw_valid,
  output logic                  tw_bypass,
  output logic                  frame_done
);
  import ifft_pkg::*;

  localparam int            BLK   = NFFT >> STAGE;
  localparam logic [LG-1:0] PMASK = LG'(BLK - 1);
  localparam logic [LG-1:0] HPOS  = LG'(BLK / 2);

  tw_state_e     state, state_nxt;
  logic [LG-1:0] n, idx, pos, pos_nxt;
  logic          last, take_lower;

  sample_pos_counter #(.NFFT(NFFT)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (in_valid),
    .n        (n),
    .last     (last)
  );

  assign pos = n & PMASK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // State tracks the half of the block the next sample falls in.
  always_comb begin
    state_nxt  = state;
    rom_addr   = '0;
    idx        = clear ? '0 : n;
    pos_nxt    = (idx + LG'(1)) & PMASK;
    take_lower = in_valid && !clear && (state == ST_LOWER);
    if (state == ST_LOWER) rom_addr = AW'((pos - HPOS) << STAGE);
    if (clear && !in_valid) state_nxt = ST_IDLE;
    else if (in_valid)      state_nxt = (pos_nxt >= HPOS) ? ST_LOWER : ST_UPPER;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tw_real    <= '0;
      tw_imag    <= '0;
      tw_valid   <= 1'b0;
      tw_bypass  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      tw_valid   <= in_valid;
      tw_bypass  <= in_valid && !take_lower;
      frame_done <= last;
      if (take_lower) begin
        tw_real <= rom_real;
        tw_imag <= rom_imag;
      end
    end
  end
endmodule

// File: tb/tb_twiddle_addr_sequencer.sv
// Four sequencer instances (STAGE 0,1,2,6) driven in lockstep against an index-based reference model.
module tb_twiddle_addr_sequencer;
  localparam int N = 128;
  localparam logic [3:0][3:0] ST = {4'd6, 4'd2, 4'd1, 4'd0};

  typedef struct {
    int          g;
    logic        tv, bp, fd;
    logic [15:0] r, i;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0;
  logic [5:0]  ra  [4];
  logic [15:0] rr  [4], ri [4], twr [4], twi [4];
  logic        tv  [4], tb  [4], fd [4];

  int n_chk = 0, n_err = 0;
  int m [4], idle [4];
  logic [15:0] hr [4], hi [4];
  exp_t sb [$];

  always #5 clk = ~clk;

  function automatic logic [15:0] rre(input logic [5:0] a);
    return {10'h2a5, a} ^ 16'h0f0f;
  endfunction
  function automatic logic [15:0] rim(input logic [5:0] a);
    return {a, 10'h13c};
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    assign rr[g] = rre(ra[g]);
    assign ri[g] = rim(ra[g]);
    twiddle_addr_sequencer #(.NFFT(N), .DATA_WIDTH(16), .STAGE(int'(ST[g]))) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .in_valid   (in_valid),
      .rom_addr   (ra[g]),
      .rom_real   (rr[g]),
      .rom_imag   (ri[g]),
      .tw_real    (twr[g]),
      .tw_imag    (twi[g]),
      .tw_valid   (tv[g]),
      .tw_bypass  (tb[g]),
      .frame_done (fd[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Address expected for the position of the next sample in dut g.
  function automatic int maddr(input int g, input int idx);
    int s, l, h, p;
    s = int'(ST[g]);
    l = N >> s;
    h = l / 2;
    p = idx % l;
    return (p >= h) ? (p - h) * (1 << s) : 0;
  endfunction

  function automatic int mlower(input int g, input int idx);
    int l;
    l = N >> int'(ST[g]);
    return ((idx % l) >= l / 2) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int g = 0; g < 4; g++) begin
      m[g] = 0; idle[g] = 1; hr[g] = '0; hi[g] = '0;
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("%s_tv%0d", tag, g), tv[g], 0);
      chk($sformatf("%s_bp%0d", tag, g), tb[g], 0);
      chk($sformatf("%s_fd%0d", tag, g), fd[g], 0);
      chk($sformatf("%s_tw%0d", tag, g), {twr[g], twi[g]}, 0);
    end
  endtask

  task automatic step(input logic v, input logic c);
    exp_t e;
    int   idx, a;
    @(negedge clk);
    in_valid = v;
    clear    = c;
    #1;
    for (int g = 0; g < 4; g++)
      chk($sformatf("addr%0d_n%0d", g, m[g]), ra[g], idle[g] ? 0 : maddr(g, m[g]));
    for (int g = 0; g < 4; g++) begin
      e.g = g; e.tv = 1'b0; e.bp = 1'b0; e.fd = 1'b0;
      if (c && !v) begin
        m[g] = 0; idle[g] = 1;
      end else if (v) begin
        idx = c ? 0 : m[g];
        e.tv = 1'b1;
        e.fd = (idx == N - 1);
        if (mlower(g, idx) != 0) begin
          a = maddr(g, idx);
          hr[g] = rre(6'(a));
          hi[g] = rim(6'(a));
        end else e.bp = 1'b1;
        m[g] = (idx + 1) % N;
        idle[g] = 0;
      end
      e.r = hr[g]; e.i = hi[g];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("tv%0d", e.g), tv[e.g], e.tv);
      chk($sformatf("bp%0d", e.g), tb[e.g], e.bp);
      chk($sformatf("fd%0d", e.g), fd[e.g], e.fd);
      chk($sformatf("twr%0d", e.g), twr[e.g], e.r);
      chk($sformatf("twi%0d", e.g), twi[e.g], e.i);
    end
  endtask

  initial begin
    model_reset();
    #1;
    chk_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // contiguous frame
    for (int k = 0; k < N; k++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // sparse: one sample every third cycle
    for (int k = 0; k < 3 * N; k++) step((k % 3) == 0, 1'b0);

    // restart with a sample at position 40
    for (int k = 0; k < 40; k++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    for (int k = 0; k < N + 2; k++) step(1'b1, 1'b0);

    // clear alone, then idle gap
    step(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0);

    // asynchronous reset mid-frame at sample 70
    for (int k = 0; k < 70; k++) step(1'b1, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    model_reset();
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) step(1'b1, 1'b0);

    // random traffic with occasional clears
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
